// File: rtl/preset_sequencer.sv
// Preset store/recall controller. Captures the last MIDI channel message from
// the parser, stores it into one of three slots on a save-mode button event,
// and replays a stored slot byte by byte to the transmitter on a normal event.
module preset_sequencer #(
  parameter int GAP_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] btn_index,
  input  logic       save_mode,
  input  logic       cap_valid,
  input  logic [7:0] cap_status,
  input  logic [7:0] cap_data1,
  input  logic [7:0] cap_data2,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_byte,
  output logic       busy,
  output logic [1:0] active_slot,
  output logic       saved,
  output logic       nack
);

  typedef enum logic [2:0] {IDLE, SEND_S, SEND_D1, SEND_D2, GAP} state_t;

  localparam int               GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST  = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
  // With no gap configured the last transfer returns straight to IDLE.
  localparam state_t           AFTER_MSG = (GAP_CYCLES > 0) ? GAP : IDLE;

  // Program Change (0xC) and Channel Pressure (0xD) carry one data byte only.
  function automatic logic is_three_byte(input logic [3:0] status_hi);
    return !((status_hi == 4'hC) || (status_hi == 4'hD));
  endfunction

  state_t           state, state_nx;
  logic [GAP_W-1:0] gap_cnt;

  logic [7:0] last_status, last_data1, last_data2;
  logic       last_valid;

  logic [7:0] slot_status [4];
  logic [7:0] slot_data1  [4];
  logic [7:0] slot_data2  [4];
  logic [3:0] slot_vld;

  logic [7:0] buf_status, buf_data1, buf_data2;

  logic       event_in;
  logic       store_ok, recall_ok, reject;
  logic [7:0] tx_byte_nx;

  assign event_in = |btn_index;

  // Next-state, event qualification and the byte to offer in the next cycle.
  always_comb begin
    state_nx   = state;
    store_ok   = 1'b0;
    recall_ok  = 1'b0;
    reject     = 1'b0;
    tx_byte_nx = 8'h00;
    case (state)
      IDLE: begin
        if (event_in) begin
          if (save_mode) begin
            if (last_valid) store_ok = 1'b1;
            else            reject   = 1'b1;
          end else if (slot_vld[btn_index]) begin
            recall_ok = 1'b1;
            state_nx  = SEND_S;
          end else begin
            reject = 1'b1;
          end
        end
      end
      SEND_S:  if (tx_ready) state_nx = SEND_D1;
      SEND_D1: if (tx_ready) state_nx = is_three_byte(buf_status[7:4]) ? SEND_D2 : AFTER_MSG;
      SEND_D2: if (tx_ready) state_nx = AFTER_MSG;
      GAP:     if (gap_cnt == GAP_LAST) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (event_in && (state != IDLE)) reject = 1'b1;
    // The send buffer loads on the same edge as the recall, so the status byte
    // is taken straight from the slot on entry.
    case (state_nx)
      SEND_S:  tx_byte_nx = recall_ok ? slot_status[btn_index] : buf_status;
      SEND_D1: tx_byte_nx = buf_data1;
      SEND_D2: tx_byte_nx = buf_data2;
      default: tx_byte_nx = 8'h00;
    endcase
  end

  // Control state and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      gap_cnt     <= '0;
      last_valid  <= 1'b0;
      slot_vld    <= 4'b0000;
      tx_valid    <= 1'b0;
      tx_byte     <= 8'h00;
      busy        <= 1'b0;
      active_slot <= 2'd0;
      saved       <= 1'b0;
      nack        <= 1'b0;
    end else begin
      state    <= state_nx;
      gap_cnt  <= (state == GAP) ? gap_cnt + 1'b1 : '0;
      tx_valid <= (state_nx == SEND_S) || (state_nx == SEND_D1) || (state_nx == SEND_D2);
      tx_byte  <= tx_byte_nx;
      busy     <= (state_nx != IDLE);
      saved    <= store_ok;
      nack     <= reject;
      if (cap_valid) last_valid <= 1'b1;
      if (store_ok) slot_vld[btn_index] <= 1'b1;
      if (store_ok || recall_ok) active_slot <= btn_index;
    end
  end

  // Message storage: capture register, preset slots and the send buffer.
  always_ff @(posedge clk) begin
    if (cap_valid) begin
      last_status <= cap_status;
      last_data1  <= cap_data1;
      last_data2  <= cap_data2;
    end
    if (store_ok) begin
      slot_status[btn_index] <= last_status;
      slot_data1[btn_index]  <= last_data1;
      slot_data2[btn_index]  <= last_data2;
    end
    if (recall_ok) begin
      buf_status <= slot_status[btn_index];
      buf_data1  <= slot_data1[btn_index];
      buf_data2  <= slot_data2[btn_index];
    end
  end

endmodule

// File: doc/preset_sequencer.md
# preset_sequencer

Preset store and recall controller sitting between the `buttons` block, the MIDI input parser and the MIDI transmitter. A button event in save mode writes the last captured MIDI channel message into the slot chosen by `btn_index`. A button event outside save mode replays that slot's stored message byte by byte to the transmitter over a valid/ready handshake. It owns the preset storage, the last-message capture register and the transmit sequencing.

## Interface
- `GAP_CYCLES`, default 0: minimum number of idle cycles, with `busy` held high, after the last byte of a recalled message before a new event is accepted.
- `clk`  in  1  system clock; every register in the block is clocked on its rising edge.
- `rst`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `btn_index`  in  2  registered slot index from `buttons`; a nonzero value for one cycle is one event.
- `save_mode`  in  1  qualifies an event as a store; it is valid in the same cycle as `btn_index`.
- `cap_valid`  in  1  one-cycle strobe: a complete channel message arrives from the parser.
- `cap_status`  in  8  status byte of the captured message (bit 7 = 1).
- `cap_data1`  in  8  first data byte.
- `cap_data2`  in  8  second data byte; ignored for 2-byte messages.
- `tx_ready`  in  1  transmitter accepts a byte.
- `tx_valid`  out  1  a byte is offered on `tx_byte`.
- `tx_byte`  out  8  byte being offered.
- `busy`  out  1  high in every state other than IDLE.
- `active_slot`  out  2  last slot that was stored or recalled.
- `saved`  out  1  one-cycle pulse: a store completed.
- `nack`  out  1  one-cycle pulse: an event was rejected (empty capture, empty slot, or busy).

## Operation
- Storage: 4 entries, indexed by `btn_index`, each holding status, data1, data2 and a valid bit. Entry 0 is never written.
- Capture register: loaded whenever `cap_valid` = 1. It holds the three bytes and sets `last_valid`.
- Message length: status high nibble 0xC or 0xD gives 2 bytes; any other value gives 3 bytes. Length is decoded from the stored status at recall time.
- States: IDLE, SEND_S, SEND_D1, SEND_D2, GAP.
- IDLE, event with `save_mode` = 1:
  - If `last_valid` = 1: copy the capture register into the slot, set the slot's valid bit, set `active_slot` to the index, pulse `saved`. State stays IDLE.
  - Otherwise: pulse `nack`.
- IDLE, event with `save_mode` = 0:
  - If the slot's valid bit is set: latch the slot contents into a send buffer, set `active_slot` to the index, go to SEND_S.
  - Otherwise: pulse `nack`.
- SEND_S: `tx_byte` = status. On `tx_ready` go to SEND_D1.
- SEND_D1: `tx_byte` = data1. On `tx_ready` go to SEND_D2 for a 3-byte message, otherwise to GAP.
- SEND_D2: `tx_byte` = data2. On `tx_ready` go to GAP.
- GAP: count `GAP_CYCLES` cycles, then go to IDLE. With `GAP_CYCLES` = 0, GAP lasts zero cycles and the last transfer goes straight to IDLE.
- Any event arriving outside IDLE is dropped and pulses `nack`. No queuing.
- `cap_valid` in the same cycle as a store event: the store uses the old capture contents, and the capture register updates on that same edge.
- A store into a slot during a recall of that slot does not occur, because events are rejected while busy. The send buffer isolates recall from later stores.

## Timing
- Reset values: `tx_valid`, `tx_byte`, `busy`, `active_slot`, `saved`, `nack` are all 0. State is IDLE, `last_valid` = 0 and every slot valid bit is cleared. Slot data contents are don't-care.
- A reset asserted mid-send aborts immediately: `tx_valid` is 0 in the cycle after the reset edge. No further bytes are sent.
- Store: event sampled at edge N. The slot is written at edge N, and `saved` is high during cycle N+1 only.
- Recall: event sampled at edge N. `tx_valid` = 1 and `busy` = 1 from cycle N+1.
- A transfer occurs at a rising edge where `tx_valid` and `tx_ready` are both 1.
- Outside reset, `tx_valid` never drops and `tx_byte` never changes until a transfer occurs.
- Best-case recall with `tx_ready` held high: 2 or 3 `tx_valid` cycles, then `GAP_CYCLES` cycles with `busy` = 1.
- All outputs are registered.

## Test plan
- Store then recall (2-byte): `cap_valid` with C0 05 xx; store event on slot 2; recall event on slot 2 with `tx_ready` = 1. Required: `saved` pulses once, then `tx_byte` sequence C0, 05. `busy` falls in the cycle after the last transfer when `GAP_CYCLES` = 0.
- 3-byte message under backpressure: capture B1 07 64; store slot 3; recall with `tx_ready` toggling 0/1. Required: B1, 07, 64 each transferred exactly once, with `tx_byte` stable while stalled.
- Rejections:
  - Recall of empty slot 1 after reset: `nack` pulses, `tx_valid` stays 0.
  - Store before any capture: `nack` pulses, slot stays invalid.
- Busy drop and gap: `GAP_CYCLES` = 3; a recall event during SEND_D1 and another during GAP each pulse `nack`. The first new event is accepted 3 cycles after the last transfer.
- Simultaneous capture and store: capture C0 01, then in a single cycle `cap_valid` with C0 09 and a store event on slot 1. Recall of slot 1 must send C0, 01.
- Mid-send reset: assert `rst` = 0 for one edge during SEND_D1. Required: `tx_valid` = 0 next cycle, all slots invalid, and a following recall pulses `nack`.
